// File: rtl/pipe_reg_stage.sv
// Valid/ready pipeline register stage with NOP bubbles and synchronous flush.
// Define PIPE_REG_SKID_EN for a main+skid pair with fully registered in_ready.
module pipe_reg_stage #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 8,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic              accept;
    logic              retire;

    assign accept = in_valid & in_ready;
    assign retire = main_valid_reg & out_ready;

`ifdef PIPE_REG_SKID_EN
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;

    // Ready depends only on state, so no out_ready -> in_ready path exists.
    assign in_ready = ~skid_valid_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= NOP_DATA;
            main_ctrl_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= NOP_DATA;
            skid_ctrl_reg  <= '0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!main_valid_reg || retire) begin
            if (skid_valid_reg) begin
                // in_ready is low while skid is full, so no accept competes here
                main_valid_reg <= 1'b1;
                main_data_reg  <= skid_data_reg;
                main_ctrl_reg  <= skid_ctrl_reg;
                skid_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= accept;
                if (accept) begin
                    main_data_reg <= in_data;
                    main_ctrl_reg <= in_ctrl;
                end
            end
        end else if (accept) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
            skid_ctrl_reg  <= in_ctrl;
        end
    end

    assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
`else
    assign in_ready = ~main_valid_reg | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= NOP_DATA;
            main_ctrl_reg  <= '0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
        end else if (accept) begin
            // covers simultaneous retire: the new entry replaces the old one
            main_valid_reg <= 1'b1;
            main_data_reg  <= in_data;
            main_ctrl_reg  <= in_ctrl;
        end else if (retire) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign occupancy = {1'b0, main_valid_reg};
`endif

    // Bubbles present NOP data and all-zero control.
    assign out_valid = main_valid_reg;
    assign out_data  = main_valid_reg ? main_data_reg : NOP_DATA;
    assign out_ctrl  = main_valid_reg ? main_ctrl_reg : '0;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Scoreboard bench for pipe_reg_stage: a queue of held entries is the reference
// model; directed scenarios followed by a long randomized run.
module tb_pipe_reg_stage;

    localparam int          DW  = 32;
    localparam int          CW  = 8;
    localparam logic [DW-1:0] NOP = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    pipe_reg_stage #(.DATA_W(DW), .CTRL_W(CW), .NOP_DATA(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_retired = 0;
    logic [CW+DW-1:0] held_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT state to the held-entry queue, then applies the
    // handshakes that the coming edge will perform.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("occupancy", occupancy, held_q.size());
            chk("out_valid", out_valid, held_q.size() != 0);
            if (held_q.size() != 0) begin
                chk("out_data", out_data, held_q[0][DW-1:0]);
                chk("out_ctrl", out_ctrl, held_q[0][CW+DW-1:DW]);
            end else begin
                chk("bubble_data", out_data, NOP);
                chk("bubble_ctrl", out_ctrl, 0);
            end
`ifdef PIPE_REG_SKID_EN
            chk("in_ready", in_ready, held_q.size() < 2);
`else
            chk("in_ready", in_ready, held_q.size() == 0 || out_ready);
`endif
            if (flush) begin
                held_q.delete();
                $display("flush");
            end else begin
                if (out_valid && out_ready && held_q.size() != 0) begin
                    $display("retire data=0x%08h ctrl=0x%02h", out_data, out_ctrl);
                    void'(held_q.pop_front());
                    n_retired++;
                end
                if (in_valid && in_ready)
                    held_q.push_back({in_ctrl, in_data});
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !flush && reset_n;
        @(posedge clk);
        #1;
    endtask

    bit acc;
    logic [DW-1:0] vals[3];
    int idx;
    int budget;
    int ret_before;

    initial begin
        // Reset state, checked while reset is held
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, NOP);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 16-entry stream at full rate
        out_ready = 1'b1;
        ret_before = n_retired;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_ctrl  = CW'(i * 3);
            tick(acc);
            chk("stream_accept", acc, 1);
        end
        in_valid = 1'b0;
        tick(acc);
        chk("stream_retired", n_retired - ret_before, 16);

        // Back-pressure with 0xA, 0xB, 0xC
        out_ready = 1'b0;
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = vals[idx];
            in_ctrl = 8'h11;
            tick(acc);
            if (acc && idx < 2) idx++;
            else if (acc) idx = 3;
        end
`ifdef PIPE_REG_SKID_EN
        chk("bp_occupancy", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_pending_idx", idx, 2);
`else
        chk("bp_occupancy", occupancy, 1);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_pending_idx", idx, 1);
`endif
        out_ready = 1'b1;
        budget = 20;
        while (idx < 3 && budget > 0) begin
            in_data = vals[idx];
            tick(acc);
            if (acc) idx++;
            budget--;
        end
        chk("bp_drain_timeout", budget == 0, 0);
        in_valid = 1'b0;
        tick(acc); tick(acc); tick(acc);

        // Flush with a full stage and a same-cycle input 0xD
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111; tick(acc);
        in_data   = 32'h2222; tick(acc);
`ifdef PIPE_REG_SKID_EN
        chk("pre_flush_occ", occupancy, 2);
`else
        chk("pre_flush_occ", occupancy, 1);
`endif
        in_data = 32'hD;
        out_ready = 1'b1;
        flush = 1'b1;
        tick(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        ret_before = n_retired;
        tick(acc); tick(acc); tick(acc);
        chk("flush_nothing_emitted", n_retired - ret_before, 0);

        // Control bits vanish once the entry retires
        in_valid = 1'b1;
        in_ctrl  = 8'hFF;
        in_data  = 32'h5A5A_0001;
        tick(acc);
        in_valid = 1'b0;
        in_ctrl  = 8'h00;
        tick(acc);
        chk("bubble_after_ff_valid", out_valid, 0);
        chk("bubble_after_ff_ctrl", out_ctrl, 0);
        chk("bubble_after_ff_data", out_data, NOP);

        // Asynchronous reset mid-stream with entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7777; in_ctrl = 8'h3C; tick(acc);
        in_data   = 32'h8888; tick(acc);
        #2;
        reset_n = 1'b0;
        held_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, NOP);
        chk("midrst_out_ctrl", out_ctrl, 0);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_data = 32'h9999; in_ctrl = 8'h42;
        reset_n = 1'b1;
        tick(acc);
        chk("first_edge_accept", acc, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(acc); tick(acc);

        // Randomized traffic against the queue model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 10;
        while (held_q.size() != 0 && budget > 0) begin
            tick(acc);
            budget--;
        end
        chk("final_drain", held_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
